// File: rtl/bin_to_bcd_seq.sv
// -----------------------------------------------------------------------------
// bin_to_bcd_seq
//
// Purpose:
//   Multi-cycle binary to packed-BCD converter using shift-and-add-3
//   (double dabble). One input bit is consumed per clock while busy.
//   The result is published with a single-cycle done pulse. Values that do not
//   fit in DIGITS decimal digits set o_ovf, and the digits saturate to all 9s.
//
// Parameters:
//   IN_W    width of the binary input (>= 1)
//   DIGITS  number of BCD output digits (1..8)
//
// Ports:
//   i_clk    system clock
//   i_rst    synchronous reset, active-high, highest priority
//   i_start  conversion request, accepted in IDLE or DONE
//   i_bin    binary value, captured only on the accepting edge
//   o_busy   high while the converter is shifting
//   o_done   one-cycle pulse when o_bcd / o_ovf (/ o_blank) are updated
//   o_bcd    packed BCD result, o_bcd[3:0] = ones digit
//   o_ovf    last conversion exceeded 10^DIGITS-1
//   o_blank  (only with BCD_LZ_BLANK_EN) per-digit leading-zero blank flags
//
// Optional build macro:
//   BCD_LZ_BLANK_EN  adds the o_blank output port and its logic.
//
// Timing:
//   Start accepted at edge N -> o_busy=1 for IN_W cycles -> o_done=1 in the
//   following cycle. A start seen while o_done is high is accepted at once,
//   so back-to-back conversions run with no idle cycle in between.
// -----------------------------------------------------------------------------
module bin_to_bcd_seq #(
    parameter int IN_W   = 10,
    parameter int DIGITS = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic [IN_W-1:0]       i_bin,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [4*DIGITS-1:0]   o_bcd,
    output logic                  o_ovf
`ifdef BCD_LZ_BLANK_EN
    ,
    output logic [DIGITS-1:0]     o_blank
`endif
);

    localparam int BCD_W = 4 * DIGITS;
    // A 1-bit input still needs a (degenerate) counter register.
    localparam int CNT_W = (IN_W > 1) ? $clog2(IN_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(IN_W - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // -------------------------------------------------------------------------
    // Helper functions
    // -------------------------------------------------------------------------

    // Add 3 to every digit that is >= 5; digits never carry into each other.
    function automatic logic [BCD_W-1:0] add3_all(input logic [BCD_W-1:0] s);
        logic [BCD_W-1:0] r;
        r = s;
        for (int i = 0; i < DIGITS; i++) begin
            if (s[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = s[4*i +: 4] + 4'd3;
            end else begin
                r[4*i +: 4] = s[4*i +: 4];
            end
        end
        return r;
    endfunction

    // Saturated result shown on overflow.
    function automatic logic [BCD_W-1:0] all_nines();
        logic [BCD_W-1:0] r;
        r = '0;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'd9;
        end
        return r;
    endfunction

`ifdef BCD_LZ_BLANK_EN
    // Digit i (i >= 1) is blanked when it and every digit above it is zero.
    // The ones digit is never blanked so a value of 0 still shows "0".
    function automatic logic [DIGITS-1:0] lz_blank(input logic [BCD_W-1:0] d);
        logic [DIGITS-1:0] b;
        logic              z;
        b = '0;
        z = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            z    = z & (d[4*i +: 4] == 4'd0);
            b[i] = z;
        end
        return b;
    endfunction
`endif

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    state_t             r_state;
    logic [IN_W-1:0]    r_shift;
    logic [BCD_W-1:0]   r_scratch;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_sticky;
    logic               r_busy;
    logic               r_done;
    logic [BCD_W-1:0]   r_bcd;
    logic               r_ovf;
`ifdef BCD_LZ_BLANK_EN
    logic [DIGITS-1:0]  r_blank;
`endif

    // -------------------------------------------------------------------------
    // Next-state wires
    // -------------------------------------------------------------------------
    state_t             w_state_nxt;
    logic [IN_W-1:0]    w_shift_nxt;
    logic [BCD_W-1:0]   w_scratch_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               w_sticky_nxt;
    logic               w_busy_nxt;
    logic               w_done_nxt;
    logic [BCD_W-1:0]   w_bcd_nxt;
    logic               w_ovf_nxt;
`ifdef BCD_LZ_BLANK_EN
    logic [DIGITS-1:0]  w_blank_nxt;
`endif

    // One double-dabble step on the current scratch/shift pair.
    logic [BCD_W-1:0]   w_adj;
    logic               w_bit_out;
    logic [BCD_W-1:0]   w_scr_shl;
    logic [IN_W-1:0]    w_shift_shl;
    logic               w_sticky_upd;

    assign w_adj        = add3_all(r_scratch);
    assign w_bit_out    = w_adj[BCD_W-1];
    assign w_scr_shl    = {w_adj[BCD_W-2:0], r_shift[IN_W-1]};
    assign w_shift_shl  = r_shift << 1;
    // A bit leaving the top digit means the value no longer fits.
    assign w_sticky_upd = r_sticky | w_bit_out;

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state, datapath and output decode.
    // Published results are computed on the final shift so that they are
    // already registered during the DONE cycle, together with the done pulse.
    always_comb begin
        w_state_nxt   = r_state;
        w_shift_nxt   = r_shift;
        w_scratch_nxt = r_scratch;
        w_cnt_nxt     = r_cnt;
        w_sticky_nxt  = r_sticky;
        w_busy_nxt    = 1'b0;
        w_done_nxt    = 1'b0;
        w_bcd_nxt     = r_bcd;
        w_ovf_nxt     = r_ovf;
`ifdef BCD_LZ_BLANK_EN
        w_blank_nxt   = r_blank;
`endif
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (i_start) begin
                    w_state_nxt   = ST_SHIFT;
                    w_shift_nxt   = i_bin;
                    w_scratch_nxt = '0;
                    w_cnt_nxt     = CNT_LOAD;
                    w_sticky_nxt  = 1'b0;
                    w_busy_nxt    = 1'b1;
                end else begin
                    w_state_nxt   = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                w_shift_nxt   = w_shift_shl;
                w_scratch_nxt = w_scr_shl;
                w_sticky_nxt  = w_sticky_upd;
                if (r_cnt == '0) begin
                    w_state_nxt = ST_DONE;
                    w_done_nxt  = 1'b1;
                    w_ovf_nxt   = w_sticky_upd;
                    if (w_sticky_upd) begin
                        w_bcd_nxt   = all_nines();
`ifdef BCD_LZ_BLANK_EN
                        w_blank_nxt = '0;
`endif
                    end else begin
                        w_bcd_nxt   = w_scr_shl;
`ifdef BCD_LZ_BLANK_EN
                        w_blank_nxt = lz_blank(w_scr_shl);
`endif
                    end
                end else begin
                    w_cnt_nxt  = r_cnt - CNT_ONE;
                    w_busy_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_shift   <= '0;
            r_scratch <= '0;
            r_cnt     <= '0;
            r_sticky  <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_bcd     <= '0;
            r_ovf     <= 1'b0;
`ifdef BCD_LZ_BLANK_EN
            r_blank   <= '0;
`endif
        end else begin
            r_shift   <= w_shift_nxt;
            r_scratch <= w_scratch_nxt;
            r_cnt     <= w_cnt_nxt;
            r_sticky  <= w_sticky_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
            r_bcd     <= w_bcd_nxt;
            r_ovf     <= w_ovf_nxt;
`ifdef BCD_LZ_BLANK_EN
            r_blank   <= w_blank_nxt;
`endif
        end
    end

    assign o_busy  = r_busy;
    assign o_done  = r_done;
    assign o_bcd   = r_bcd;
    assign o_ovf   = r_ovf;
`ifdef BCD_LZ_BLANK_EN
    assign o_blank = r_blank;
`endif

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// -----------------------------------------------------------------------------
// tb_bin_to_bcd_seq
//
// Self-checking bench for bin_to_bcd_seq. Four instances:
//   dut0 IN_W=10 DIGITS=4, dut1 IN_W=14 DIGITS=4,
//   dut2 IN_W=8  DIGITS=3, dut3 IN_W=1  DIGITS=1.
// Expected results come from an arithmetic decimal model and are queued when
// a start is driven; a per-instance monitor pops and compares on each done.
// -----------------------------------------------------------------------------
module tb_bin_to_bcd_seq;

    typedef struct packed {
        logic [31:0] bcd;
        logic        ovf;
        logic [7:0]  blank;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic        start0, busy0, done0, ovf0;
    logic [9:0]  bin0;
    logic [15:0] bcd0;
    logic        start1, busy1, done1, ovf1;
    logic [13:0] bin1;
    logic [15:0] bcd1;
    logic        start2, busy2, done2, ovf2;
    logic [7:0]  bin2;
    logic [11:0] bcd2;
    logic        start3, busy3, done3, ovf3;
    logic [0:0]  bin3;
    logic [3:0]  bcd3;
    logic [7:0]  bl0, bl1, bl2, bl3;

`ifdef BCD_LZ_BLANK_EN
    logic [3:0] blank0;
    logic [3:0] blank1;
    logic [2:0] blank2;
    logic [0:0] blank3;
    assign bl0 = 8'(blank0);
    assign bl1 = 8'(blank1);
    assign bl2 = 8'(blank2);
    assign bl3 = 8'(blank3);
`else
    assign bl0 = 8'd0;
    assign bl1 = 8'd0;
    assign bl2 = 8'd0;
    assign bl3 = 8'd0;
`endif

    bin_to_bcd_seq #(.IN_W(10), .DIGITS(4)) dut0 (
        .i_clk(clk), .i_rst(rst), .i_start(start0), .i_bin(bin0),
        .o_busy(busy0), .o_done(done0), .o_bcd(bcd0), .o_ovf(ovf0)
`ifdef BCD_LZ_BLANK_EN
        , .o_blank(blank0)
`endif
    );
    bin_to_bcd_seq #(.IN_W(14), .DIGITS(4)) dut1 (
        .i_clk(clk), .i_rst(rst), .i_start(start1), .i_bin(bin1),
        .o_busy(busy1), .o_done(done1), .o_bcd(bcd1), .o_ovf(ovf1)
`ifdef BCD_LZ_BLANK_EN
        , .o_blank(blank1)
`endif
    );
    bin_to_bcd_seq #(.IN_W(8), .DIGITS(3)) dut2 (
        .i_clk(clk), .i_rst(rst), .i_start(start2), .i_bin(bin2),
        .o_busy(busy2), .o_done(done2), .o_bcd(bcd2), .o_ovf(ovf2)
`ifdef BCD_LZ_BLANK_EN
        , .o_blank(blank2)
`endif
    );
    bin_to_bcd_seq #(.IN_W(1), .DIGITS(1)) dut3 (
        .i_clk(clk), .i_rst(rst), .i_start(start3), .i_bin(bin3),
        .o_busy(busy3), .o_done(done3), .o_bcd(bcd3), .o_ovf(ovf3)
`ifdef BCD_LZ_BLANK_EN
        , .o_blank(blank3)
`endif
    );

    int errors = 0;
    int checks = 0;
    int dcnt0 = 0, dcnt1 = 0, dcnt2 = 0, dcnt3 = 0;
    logic prev_done0 = 1'b0;

    exp_t sb0[$];
    exp_t sb1[$];
    exp_t sb2[$];
    exp_t sb3[$];

    // ---------------- model ----------------
    function automatic int pow10(input int n);
        int p;
        p = 1;
        for (int i = 0; i < n; i++) p = p * 10;
        return p;
    endfunction

    function automatic exp_t model(input int v, input int d);
        exp_t e;
        int   x;
        e = '0;
        if (v >= pow10(d)) begin
            e.ovf = 1'b1;
            for (int i = 0; i < d; i++) e.bcd[4*i +: 4] = 4'd9;
        end else begin
            x = v;
            for (int i = 0; i < d; i++) begin
                e.bcd[4*i +: 4] = 4'(x % 10);
                x = x / 10;
            end
            for (int i = 1; i < d; i++) e.blank[i] = (v < pow10(i));
        end
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic sb_compare(input int which, input logic [31:0] obs_bcd,
                              input logic obs_ovf, input logic [7:0] obs_blank);
        exp_t e;
        int   sz;
        case (which)
            0: sz = sb0.size();
            1: sz = sb1.size();
            2: sz = sb2.size();
            default: sz = sb3.size();
        endcase
        checks++;
        assert (sz > 0) else begin
            errors++;
            $error("FAIL sb_unexpected_done_dut%0d: observed pending=%0d expected pending>=%0d", which, sz, 1);
        end
        if (sz > 0) begin
            case (which)
                0: e = sb0.pop_front();
                1: e = sb1.pop_front();
                2: e = sb2.pop_front();
                default: e = sb3.pop_front();
            endcase
            chk($sformatf("dut%0d_bcd", which), obs_bcd, e.bcd);
            chk($sformatf("dut%0d_ovf", which), 32'(obs_ovf), 32'(e.ovf));
`ifdef BCD_LZ_BLANK_EN
            chk($sformatf("dut%0d_blank", which), 32'(obs_blank), 32'(e.blank));
`endif
        end
    endtask

    // ---------------- monitors ----------------
    always @(negedge clk) begin
        if (done0) begin
            dcnt0++;
            chk("dut0_done_single_cycle", 32'(prev_done0), 32'd0);
            sb_compare(0, 32'(bcd0), ovf0, bl0);
        end
        prev_done0 = done0;
        if (done1) begin dcnt1++; sb_compare(1, 32'(bcd1), ovf1, bl1); end
        if (done2) begin dcnt2++; sb_compare(2, 32'(bcd2), ovf2, bl2); end
        if (done3) begin dcnt3++; sb_compare(3, 32'(bcd3), ovf3, bl3); end
    end

    function automatic logic get_done(input int which);
        case (which)
            0: return done0;
            1: return done1;
            2: return done2;
            default: return done3;
        endcase
    endfunction

    function automatic logic get_busy(input int which);
        case (which)
            0: return busy0;
            1: return busy1;
            2: return busy2;
            default: return busy3;
        endcase
    endfunction

    // Drive one start pulse, queue the expectation, then wait (bounded) for
    // done and check latency and busy length. Returns at the done-cycle negedge.
    task automatic conv(input int which, input int v);
        int lat, busy_n, in_w, dg;
        case (which)
            0: begin in_w = 10; dg = 4; start0 = 1'b1; bin0 = 10'(v); sb0.push_back(model(v, dg)); end
            1: begin in_w = 14; dg = 4; start1 = 1'b1; bin1 = 14'(v); sb1.push_back(model(v, dg)); end
            2: begin in_w = 8;  dg = 3; start2 = 1'b1; bin2 = 8'(v);  sb2.push_back(model(v, dg)); end
            default: begin in_w = 1; dg = 1; start3 = 1'b1; bin3 = 1'(v); sb3.push_back(model(v, dg)); end
        endcase
        @(posedge clk); #1;
        // Scramble the input after acceptance; the result must not change.
        start0 = 1'b0; start1 = 1'b0; start2 = 1'b0; start3 = 1'b0;
        bin0 = 10'($urandom); bin1 = 14'($urandom); bin2 = 8'($urandom); bin3 = 1'($urandom);
        lat = 0;
        busy_n = 0;
        do begin
            @(negedge clk);
            lat++;
            if (get_busy(which)) busy_n++;
        end while (!get_done(which) && lat < 40);
        chk($sformatf("dut%0d_latency_bin%0d", which, v), 32'(lat), 32'(in_w + 1));
        chk($sformatf("dut%0d_busy_cycles_bin%0d", which, v), 32'(busy_n), 32'(in_w));
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // ---------------- directed sequence ----------------
    initial begin : main_seq
        int d;
        rst = 1'b1;
        start0 = 1'b0; start1 = 1'b0; start2 = 1'b0; start3 = 1'b0;
        bin0 = '0; bin1 = '0; bin2 = '0; bin3 = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_busy", 32'(busy0), 32'd0);
        chk("reset_done", 32'(done0), 32'd0);
        chk("reset_bcd", 32'(bcd0), 32'd0);
        chk("reset_ovf", 32'(ovf0), 32'd0);
        chk("reset_bcd_dut1", 32'(bcd1), 32'd0);
`ifdef BCD_LZ_BLANK_EN
        chk("reset_blank", 32'(blank0), 32'd0);
`endif
        idle(1);

        // Basic conversion from IDLE.
        conv(0, 1000);
        idle(2);

        // Back-to-back: second start driven during the first done cycle.
        conv(0, 1023);
        conv(0, 59);
        idle(2);

        // Leading-zero cases.
        conv(0, 0);   idle(2);
        conv(0, 7);   idle(2);
        conv(0, 305); idle(2);

        // start re-asserted in cycles 3-5 of a conversion must be ignored.
        d = dcnt0;
        start0 = 1'b1; bin0 = 10'd500; sb0.push_back(model(500, 4));
        @(posedge clk); #1;
        start0 = 1'b0; bin0 = 10'd0;
        idle(2);
        start0 = 1'b1; bin0 = 10'd999;
        idle(3);
        start0 = 1'b0;
        idle(20);
        chk("dut0_one_done_ignored_start", 32'(dcnt0 - d), 32'd1);

        // Reset in the middle of a conversion aborts it without a done.
        start0 = 1'b1; bin0 = 10'd600;
        @(posedge clk); #1;
        start0 = 1'b0;
        idle(4);
        rst = 1'b1;
        d = dcnt0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_busy", 32'(busy0), 32'd0);
        chk("abort_bcd", 32'(bcd0), 32'd0);
        chk("abort_ovf", 32'(ovf0), 32'd0);
        idle(20);
        chk("abort_no_done", 32'(dcnt0 - d), 32'd0);
        conv(0, 123);
        idle(2);

        // Wider input: overflow saturates, 9999 fits exactly.
        conv(1, 12345); idle(2);
        conv(1, 9999);  idle(2);
        conv(1, 16383); idle(2);

        // Three digits, eight bits.
        conv(2, 255); idle(2);
        conv(2, 100); idle(2);

        // Single-bit input, back to back.
        conv(3, 1);
        conv(3, 0);
        conv(3, 1);
        idle(3);

        chk("scoreboard_drained", 32'(sb0.size() + sb1.size() + sb2.size() + sb3.size()), 32'd0);
        chk("dut1_done_count", 32'(dcnt1), 32'd3);
        chk("dut3_done_count", 32'(dcnt3), 32'd3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bin_to_bcd_seq.md
Name: bin_to_bcd_seq

Overview:
- Parametrised, multi-cycle binary-to-BCD converter using shift-and-add-3 (double dabble).
- Next generation of the fixed thousands/hundreds/tens/ones splitter: input width and digit count are generic, with a start/done handshake, overflow detection and optional leading-zero blanking.
- Sits between the calendar/clock counters and the 7-segment multiplexer; one conversion per request.

Parameters:
- IN_W, 10, width of binary input (10 covers 0..1023).
- DIGITS, 4, number of BCD output digits; range 1..8.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- start  in  1  conversion request; sampled on rising clk edge.
- bin  in  IN_W  binary value; captured only in the cycle start is accepted.
- busy  out  1  high while a conversion is in progress (SHIFT state).
- done  out  1  single-cycle pulse when bcd/ovf are updated.
- bcd  out  4*DIGITS  packed result; digit 0 = bcd[3:0] = ones.
- ovf  out  1  value exceeded 10^DIGITS-1 in the last conversion.

Behaviour:
- Reset (rst=1 at posedge): state=IDLE, busy=0, done=0, bcd=0, ovf=0, scratch cleared. This takes priority over everything, including mid-conversion; an aborted conversion produces no done.
- States: IDLE, SHIFT, DONE.
- IDLE: if start=1, latch bin into shift register, clear BCD scratch and overflow flag, load bit counter = IN_W-1, go SHIFT. Otherwise stay.
- SHIFT, one bit per cycle:
  - First, every 4-bit scratch digit >= 5 gets +3 (4-bit add, no carry between digits).
  - Then {scratch, shift register} is shifted left by 1.
  - A 1 shifted out of the top of the scratch sets the sticky overflow flag.
  - When the counter reaches 0, go DONE; otherwise decrement.
  - start is ignored in SHIFT.
- DONE: register bcd and ovf outputs, done=1 for this cycle only, busy=0.
  - If ovf, bcd = all digits 9 (saturate).
  - If start=1 in DONE, it is accepted exactly as in IDLE (back-to-back, next state SHIFT). Otherwise go IDLE.
- Latency: start accepted at edge N, busy=1 for cycles N+1..N+IN_W, done=1 in cycle N+IN_W+1. Throughput is one conversion per IN_W+1 cycles.
- bcd/ovf hold their previous values between done pulses; they never show intermediate scratch.
- bin changes after acceptance do not affect the running conversion.
- IN_W=1: a single SHIFT cycle; must still work.

Optional Feature:
- Macro: BCD_LZ_BLANK_EN.
- Defined:
  - Extra output port blank [DIGITS-1:0], registered and updated together with bcd at done; reset value 0.
  - blank[i]=1 when digit i and all higher digits are 0, for i>=1.
  - blank[0] is always 0.
  - When ovf, blank=0.
- Not defined: port and logic absent; all other behaviour identical.

Test Plan:
- IN_W=10, DIGITS=4, bin=1000, start pulse -> done exactly 11 cycles later, bcd=16'h1000, ovf=0, busy high for 10 cycles.
- bin=1023 then back-to-back start asserted during the done cycle with bin=59 -> first done gives bcd=16'h1023; second done 11 cycles later gives bcd=16'h0059, no idle gap.
- bin=0 with BCD_LZ_BLANK_EN -> bcd=16'h0000, blank=4'b1110. bin=7 -> blank=4'b1110. bin=305 -> blank=4'b1000.
- start re-asserted on cycles 3-5 of a conversion with a different bin -> ignored; result matches the first bin; only one done pulse.
- rst asserted in cycle 5 of a conversion -> next cycle busy=0, bcd=0, ovf=0; no done pulse; a subsequent start converts correctly.
- Instance IN_W=14, DIGITS=4, bin=12345 -> ovf=1, bcd=16'h9999. bin=9999 -> ovf=0, bcd=16'h9999. Instance IN_W=8, DIGITS=3, bin=255 -> bcd=12'h255.
